// File: rtl/dmem_pkg.sv
// Shared widths and requester port indices for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned N_PORTS = 2;

    localparam logic [0:0] PORT_INT = 1'b0;
    localparam logic [0:0] PORT_FP  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = dmem_pkg::ADDR_W,
    parameter int unsigned DATA_W = dmem_pkg::DATA_W
);

    logic              R0_REQ;
    logic              R0_WE;
    logic [ADDR_W-1:0] R0_ADDR;
    logic [DATA_W-1:0] R0_WD;
    logic              R0_GNT;
    logic              R0_RVALID;
    logic [DATA_W-1:0] R0_RDATA;

    logic              R1_REQ;
    logic              R1_WE;
    logic [ADDR_W-1:0] R1_ADDR;
    logic [DATA_W-1:0] R1_WD;
    logic              R1_GNT;
    logic              R1_RVALID;
    logic [DATA_W-1:0] R1_RDATA;

    logic [ADDR_W-1:0] MEM_A;
    logic              MEM_WE;
    logic [DATA_W-1:0] MEM_WD;
    logic [DATA_W-1:0] MEM_RD;

    // Arbiter side
    modport slave (
        input  R0_REQ, R0_WE, R0_ADDR, R0_WD,
        input  R1_REQ, R1_WE, R1_ADDR, R1_WD,
        input  MEM_RD,
        output R0_GNT, R0_RVALID, R0_RDATA,
        output R1_GNT, R1_RVALID, R1_RDATA,
        output MEM_A, MEM_WE, MEM_WD
    );

    // Requesters plus memory
    modport master (
        output R0_REQ, R0_WE, R0_ADDR, R0_WD,
        output R1_REQ, R1_WE, R1_ADDR, R1_WD,
        output MEM_RD,
        input  R0_GNT, R0_RVALID, R0_RDATA,
        input  R1_GNT, R1_RVALID, R1_RDATA,
        input  MEM_A, MEM_WE, MEM_WD
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a one-bit last-granted pointer.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;

    // Conflict goes to the port that did not win last; reset favours port 0
    always_comb begin
        gnt = 2'b00;
        if (!RST) begin
            if (req == 2'b11) begin
                gnt = (last_q == PORT_FP) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q <= PORT_FP;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the integer and FP load/store units.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = dmem_pkg::ADDR_W,
    parameter int unsigned DATA_W = dmem_pkg::DATA_W
)(
    input  logic           CLK,
    input  logic           RST,
    dmem_arbiter_if.slave  bus
);

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] mem_a_c;
    logic [DATA_W-1:0] mem_wd_c;
    logic              ld0_c;
    logic              ld1_c;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    assign req = {bus.R1_REQ, bus.R0_REQ};

    rr_arb2 u_arb (
        .CLK (CLK),
        .RST (RST),
        .req (req),
        .gnt (gnt)
    );

    assign bus.R0_GNT = gnt[0];
    assign bus.R1_GNT = gnt[1];

    // Port 0 drives the memory bus when idle
    assign mem_a_c  = gnt[1] ? bus.R1_ADDR : bus.R0_ADDR;
    assign mem_wd_c = gnt[1] ? bus.R1_WD   : bus.R0_WD;

    assign bus.MEM_A  = mem_a_c;
    assign bus.MEM_WD = mem_wd_c;
    assign bus.MEM_WE = (gnt[0] & bus.R0_WE) | (gnt[1] & bus.R1_WE);

    assign ld0_c = gnt[0] & ~bus.R0_WE;
    assign ld1_c = gnt[1] & ~bus.R1_WE;

    // Load data is captured at the edge that closes the grant cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= ld0_c;
            rvalid1_q <= ld1_c;
            if (ld0_c) begin
                rdata0_q <= bus.MEM_RD;
            end
            if (ld1_c) begin
                rdata1_q <= bus.MEM_RD;
            end
        end
    end

    assign bus.R0_RVALID = rvalid0_q;
    assign bus.R1_RVALID = rvalid1_q;
    assign bus.R0_RDATA  = rdata0_q;
    assign bus.R1_RDATA  = rdata1_q;

endmodule
